// File: rtl/multi_channel_p2s.sv
// Multi-channel parallel-to-serial converter.
// Each channel owns a one-word holding buffer and a shift register. When every
// channel has a word pending, all holdings move into the shift registers at once
// and the frame is shifted out in lock-step, one bit per channel per clock.
// The next word set may be collected while a frame is still shifting; if it is
// complete by the last bit, the next frame follows with no gap cycle.
module multi_channel_p2s #(
    parameter int DATA_W    = 40,
    parameter int N_CH      = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic                     Sclk,
    input  logic                     uni_reset_n,
    input  logic                     flush,
    input  logic [N_CH-1:0]          ch_finish,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic                     OutReady,
    output logic [N_CH-1:0]          serial_out,
    output logic                     frame_start,
    output logic [N_CH-1:0]          pending,
    output logic [N_CH-1:0]          overrun
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   holding_r [N_CH];
    logic [DATA_W-1:0]   shift_r   [N_CH];
    logic [N_CH-1:0]     pending_r;
    logic [N_CH-1:0]     overrun_r;
    logic [N_CH-1:0]     serial_r;
    logic                out_ready_r;
    logic                frame_start_r;

    logic                all_pending_s;
    logic                last_bit_s;
    logic                xfer_s;

    // Bit presented on the line for a given shift-register content.
    function automatic logic out_bit(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[DATA_W-1];
        end else begin
            return w[0];
        end
    endfunction

    // One shift step toward the output end, filling with zero.
    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return {w[DATA_W-2:0], 1'b0};
        end else begin
            return {1'b0, w[DATA_W-1:1]};
        end
    endfunction

    // Transfer decision: all channels pending, and the line is idle or on its last bit.
    always_comb begin
        all_pending_s = &pending_r;
        last_bit_s    = (state_r == SHIFT) && (cnt_r == CNT_LAST);
        xfer_s        = all_pending_s && ((state_r == IDLE) || last_bit_s);
    end

    // Holding buffers: capture new words, track pending and sticky overrun per channel.
    always_ff @(posedge Sclk or negedge uni_reset_n) begin
        if (!uni_reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                holding_r[c] <= {DATA_W{1'b0}};
            end
            pending_r <= {N_CH{1'b0}};
            overrun_r <= {N_CH{1'b0}};
        end else if (flush) begin
            pending_r <= {N_CH{1'b0}};
            overrun_r <= {N_CH{1'b0}};
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_finish[c]) begin
                    // A word arriving on the transfer edge refills the buffer being emptied.
                    if (!pending_r[c] || xfer_s) begin
                        holding_r[c] <= ch_data[c*DATA_W +: DATA_W];
                        pending_r[c] <= 1'b1;
                    end else begin
                        overrun_r[c] <= 1'b1;
                    end
                end else if (xfer_s) begin
                    pending_r[c] <= 1'b0;
                end else begin
                    pending_r[c] <= pending_r[c];
                end
            end
        end
    end

    // Framing FSM: loads shift registers, counts bits and drives registered line outputs.
    always_ff @(posedge Sclk or negedge uni_reset_n) begin
        if (!uni_reset_n) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            out_ready_r   <= 1'b0;
            frame_start_r <= 1'b0;
            serial_r      <= {N_CH{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                shift_r[c] <= {DATA_W{1'b0}};
            end
        end else if (flush) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            out_ready_r   <= 1'b0;
            frame_start_r <= 1'b0;
            serial_r      <= {N_CH{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                shift_r[c] <= {DATA_W{1'b0}};
            end
        end else if (xfer_s) begin
            // Start of a frame, either from IDLE or back-to-back after the last bit.
            state_r       <= SHIFT;
            cnt_r         <= {CNT_W{1'b0}};
            out_ready_r   <= 1'b1;
            frame_start_r <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                shift_r[c]  <= holding_r[c];
                serial_r[c] <= out_bit(holding_r[c]);
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r       <= IDLE;
                    cnt_r         <= {CNT_W{1'b0}};
                    out_ready_r   <= 1'b0;
                    frame_start_r <= 1'b0;
                    serial_r      <= {N_CH{1'b0}};
                end
                SHIFT: begin
                    if (last_bit_s) begin
                        state_r       <= IDLE;
                        cnt_r         <= {CNT_W{1'b0}};
                        out_ready_r   <= 1'b0;
                        frame_start_r <= 1'b0;
                        serial_r      <= {N_CH{1'b0}};
                        for (int c = 0; c < N_CH; c++) begin
                            shift_r[c] <= {DATA_W{1'b0}};
                        end
                    end else begin
                        state_r       <= SHIFT;
                        cnt_r         <= cnt_r + CNT_ONE;
                        out_ready_r   <= 1'b1;
                        frame_start_r <= 1'b0;
                        for (int c = 0; c < N_CH; c++) begin
                            shift_r[c]  <= shift_word(shift_r[c]);
                            serial_r[c] <= out_bit(shift_word(shift_r[c]));
                        end
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    cnt_r         <= {CNT_W{1'b0}};
                    out_ready_r   <= 1'b0;
                    frame_start_r <= 1'b0;
                    serial_r      <= {N_CH{1'b0}};
                end
            endcase
        end
    end

    assign OutReady    = out_ready_r;
    assign frame_start = frame_start_r;
    assign serial_out  = serial_r;
    assign pending     = pending_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_multi_channel_p2s.sv
// Bench for multi_channel_p2s: default 2x40 LSB-first instance with a frame
// scoreboard, plus a 1x8 MSB-first instance for bit-order checks.
module tb_multi_channel_p2s;

    logic        Sclk;
    logic        uni_reset_n;
    logic        flush;
    logic [1:0]  ch_finish;
    logic [79:0] ch_data;
    logic        OutReady;
    logic [1:0]  serial_out;
    logic        frame_start;
    logic [1:0]  pending;
    logic [1:0]  overrun;

    logic [0:0]  fin8;
    logic [7:0]  data8;
    logic        ready8;
    logic [0:0]  so8;
    logic        fs8;
    logic [0:0]  pend8;
    logic [0:0]  ovr8;

    int total = 0;
    int bad   = 0;

    // expected frames, {R word, L word}
    logic [79:0] sb_q[$];

    multi_channel_p2s dut (
        .Sclk(Sclk), .uni_reset_n(uni_reset_n), .flush(flush),
        .ch_finish(ch_finish), .ch_data(ch_data),
        .OutReady(OutReady), .serial_out(serial_out), .frame_start(frame_start),
        .pending(pending), .overrun(overrun)
    );

    multi_channel_p2s #(.DATA_W(8), .N_CH(1), .MSB_FIRST(1)) dut8 (
        .Sclk(Sclk), .uni_reset_n(uni_reset_n), .flush(flush),
        .ch_finish(fin8), .ch_data(data8),
        .OutReady(ready8), .serial_out(so8), .frame_start(fs8),
        .pending(pend8), .overrun(ovr8)
    );

    initial begin
        Sclk = 1'b0;
        forever #5 Sclk = ~Sclk;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive a finish strobe for one edge; returns #1 after that edge.
    task automatic drive(input logic [1:0] mask, input logic [39:0] l, input logic [39:0] r);
        ch_finish = mask;
        ch_data   = {r, l};
        @(posedge Sclk);
        #1;
        ch_finish = 2'b00;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge Sclk);
        #1;
    endtask

    // Scoreboard monitor: every shifted bit is compared with the frame popped at frame_start.
    initial begin
        logic [79:0] cur;
        logic [1:0]  exp_bits;
        int          idx;
        cur = 80'd0;
        idx = 0;
        forever begin
            @(negedge Sclk);
            if (uni_reset_n) begin
                if (OutReady) begin
                    if (frame_start) begin
                        if (sb_q.size() == 0) begin
                            check("sb_unexpected_frame", 80'd1, 80'd0);
                            cur = 80'd0;
                        end else begin
                            cur = sb_q.pop_front();
                        end
                        idx = 0;
                    end
                    check("frame_len", {79'd0, idx < 40}, 80'd1);
                    if (idx < 40) begin
                        exp_bits = {cur[40 + idx], cur[idx]};
                        check("serial_bit", {78'd0, serial_out}, {78'd0, exp_bits});
                    end
                    idx++;
                end else begin
                    check("idle_line", {77'd0, frame_start, serial_out}, 80'd0);
                end
            end
        end
    end

    initial begin
        logic [7:0]  a5;
        int          fs_cnt;
        int          fs_first;
        int          fs_second;
        logic        ready_all;
        logic [39:0] wa_l, wa_r, wb_l, wb_r;

        uni_reset_n = 1'b0;
        flush       = 1'b0;
        ch_finish   = 2'b00;
        ch_data     = 80'd0;
        fin8        = 1'b0;
        data8       = 8'd0;
        #12;
        check("rst_outready", {79'd0, OutReady}, 80'd0);
        check("rst_serial", {78'd0, serial_out}, 80'd0);
        check("rst_fs", {79'd0, frame_start}, 80'd0);
        check("rst_pending", {78'd0, pending}, 80'd0);
        check("rst_overrun", {78'd0, overrun}, 80'd0);
        @(negedge Sclk);
        uni_reset_n = 1'b1;
        wait_edges(2);

        // Basic frame with known leading bits
        sb_q.push_back({40'h80_0000_0001, 40'h00_0000_0005});
        drive(2'b11, 40'h00_0000_0005, 40'h80_0000_0001);
        check("basic_pending", {78'd0, pending}, 80'd3);
        check("basic_not_ready", {79'd0, OutReady}, 80'd0);
        wait_edges(1);
        check("basic_ready", {79'd0, OutReady}, 80'd1);
        check("basic_fs", {79'd0, frame_start}, 80'd1);
        check("basic_bit0", {78'd0, serial_out}, 80'd3);
        check("basic_pend_clr", {78'd0, pending}, 80'd0);
        wait_edges(1);
        check("basic_bit1", {78'd0, serial_out}, 80'd0);
        check("basic_fs_low", {79'd0, frame_start}, 80'd0);
        wait_edges(1);
        check("basic_bit2", {78'd0, serial_out}, 80'd1);
        wait_edges(38);
        check("basic_end", {79'd0, OutReady}, 80'd0);
        wait_edges(3);

        // Back-to-back frames with no gap
        wa_l = 40'h12_3456_789A; wa_r = 40'hFE_DCBA_9876;
        wb_l = 40'hA5_5A0F_F0C3; wb_r = 40'h01_8024_4218;
        sb_q.push_back({wa_r, wa_l});
        sb_q.push_back({wb_r, wb_l});
        drive(2'b11, wa_l, wa_r);
        fs_cnt = 0; fs_first = 0; fs_second = 0; ready_all = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            if (i > 1) begin
                @(posedge Sclk);
                #1;
            end else begin
                @(posedge Sclk);
                #1;
            end
            ch_finish = 2'b00;
            if (!OutReady) ready_all = 1'b0;
            if (frame_start) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = i;
                if (fs_cnt == 2) fs_second = i;
            end
            if (i == 10) begin
                ch_finish = 2'b11;
                ch_data   = {wb_r, wb_l};
            end
        end
        check("b2b_ready_held", {79'd0, ready_all}, 80'd1);
        check("b2b_fs_count", 80'(fs_cnt), 80'd2);
        check("b2b_fs_gap", 80'(fs_second - fs_first), 80'd40);
        wait_edges(1);
        check("b2b_end", {79'd0, OutReady}, 80'd0);
        wait_edges(2);

        // Skewed channel arrival
        sb_q.push_back({40'h33_CC33_CC33, 40'h0F_1E2D_3C4B});
        drive(2'b01, 40'h0F_1E2D_3C4B, 40'd0);
        for (int i = 1; i <= 9; i++) begin
            wait_edges(1);
            check("skew_pending", {78'd0, pending}, 80'd1);
            check("skew_idle", {79'd0, OutReady}, 80'd0);
        end
        drive(2'b10, 40'd0, 40'h33_CC33_CC33);
        check("skew_e10_idle", {79'd0, OutReady}, 80'd0);
        check("skew_e10_pend", {78'd0, pending}, 80'd3);
        wait_edges(1);
        check("skew_e11_ready", {79'd0, OutReady}, 80'd1);
        check("skew_e11_fs", {79'd0, frame_start}, 80'd1);
        wait_edges(41);

        // Finish on the transfer edge reloads holding without overrun
        sb_q.push_back({40'h11_1111_1111, 40'h22_2222_2222});
        sb_q.push_back({40'h44_4444_4444, 40'h88_8888_8888});
        drive(2'b11, 40'h22_2222_2222, 40'h11_1111_1111);
        drive(2'b11, 40'h88_8888_8888, 40'h44_4444_4444);
        check("xfer_edge_fs", {79'd0, frame_start}, 80'd1);
        check("xfer_edge_pend", {78'd0, pending}, 80'd3);
        check("xfer_edge_ovr", {78'd0, overrun}, 80'd0);
        wait_edges(82);
        check("xfer_edge_end", {79'd0, OutReady}, 80'd0);

        // Overrun: second L word dropped, first one emitted
        sb_q.push_back({40'h66_0000_0066, 40'hC3_0000_003C});
        drive(2'b01, 40'hC3_0000_003C, 40'd0);
        wait_edges(1);
        drive(2'b01, 40'hFF_FFFF_FFFF, 40'd0);
        check("ovr_flag", {78'd0, overrun}, 80'd1);
        check("ovr_pending", {78'd0, pending}, 80'd1);
        drive(2'b10, 40'd0, 40'h66_0000_0066);
        wait_edges(42);
        check("ovr_sticky", {78'd0, overrun}, 80'd1);
        check("ovr_idle", {79'd0, OutReady}, 80'd0);
        flush = 1'b1;
        wait_edges(1);
        flush = 1'b0;
        check("flush_ovr", {78'd0, overrun}, 80'd0);
        check("flush_pend", {78'd0, pending}, 80'd0);

        // Flush mid-frame aborts output
        sb_q.push_back({40'h5A_5A5A_5A5A, 40'hA5_A5A5_A5A5});
        drive(2'b11, 40'hA5_A5A5_A5A5, 40'h5A_5A5A_5A5A);
        wait_edges(6);
        flush = 1'b1;
        wait_edges(1);
        flush = 1'b0;
        check("flush_mid_ready", {79'd0, OutReady}, 80'd0);
        check("flush_mid_serial", {78'd0, serial_out}, 80'd0);
        wait_edges(5);

        // Reset mid-frame, with a stray L word pending
        sb_q.push_back({40'h00_FF00_FF00, 40'hFF_00FF_00FF});
        drive(2'b11, 40'hFF_00FF_00FF, 40'h00_FF00_FF00);
        wait_edges(9);
        drive(2'b01, 40'h99_9999_9999, 40'd0);
        wait_edges(10);
        #1;
        uni_reset_n = 1'b0;
        #1;
        check("rstmid_ready", {79'd0, OutReady}, 80'd0);
        check("rstmid_serial", {78'd0, serial_out}, 80'd0);
        check("rstmid_fs", {79'd0, frame_start}, 80'd0);
        check("rstmid_pend", {78'd0, pending}, 80'd0);
        @(negedge Sclk);
        uni_reset_n = 1'b1;
        wait_edges(2);
        drive(2'b10, 40'd0, 40'h77_7777_7777);
        ready_all = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_edges(1);
            if (OutReady) ready_all = 1'b1;
        end
        check("rstmid_stays_idle", {79'd0, ready_all}, 80'd0);
        check("rstmid_pend_r", {78'd0, pending}, 80'd2);
        sb_q.push_back({40'h77_7777_7777, 40'h12_0000_0034});
        drive(2'b01, 40'h12_0000_0034, 40'd0);
        wait_edges(1);
        check("rstmid_new_fs", {79'd0, frame_start}, 80'd1);
        wait_edges(41);

        // MSB-first 8-bit single channel
        a5 = 8'hA5;
        fin8 = 1'b1;
        data8 = a5;
        @(posedge Sclk);
        #1;
        fin8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_edges(1);
            check("msb_ready", {79'd0, ready8}, 80'd1);
            check("msb_bit", {79'd0, so8}, {79'd0, a5[7 - i]});
            check("msb_fs", {79'd0, fs8}, {79'd0, (i == 0)});
        end
        wait_edges(1);
        check("msb_end", {79'd0, ready8}, 80'd0);

        wait_edges(3);
        check("sb_empty", 80'(sb_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_p2s.md
MULTI_CHANNEL_P2S -- requirements
Module: multi_channel_p2s

Interface
REQ-001 SHALL have parameter DATA_W, default 40, word width per channel (range 2..64).
REQ-002 SHALL have parameter N_CH, default 2, channel count (range 1..8).
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 = LSB first, 1 = MSB first.
REQ-004 SHALL have port Sclk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port uni_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous abort/clear.
REQ-007 SHALL have port ch_finish  input  N_CH  per-channel word-valid strobe.
REQ-008 SHALL have port ch_data  input  N_CH*DATA_W  channel c word at [c*DATA_W +: DATA_W].
REQ-009 SHALL have port OutReady  output  1  high while a frame is being shifted.
REQ-010 SHALL have port serial_out  output  N_CH  serial bit per channel.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse coincident with bit 0 of each frame.
REQ-012 SHALL have port pending  output  N_CH  holding-buffer valid flags.
REQ-013 SHALL have port overrun  output  N_CH  sticky per-channel overrun flags.

Function
REQ-014 SHALL contain per channel a one-word holding buffer with valid bit, plus a DATA_W shift register; shifting and loading of the next word overlap.
REQ-015 ch_finish[c] sampled at edge k SHALL write ch_data word c into holding[c] and set pending[c] after edge k.
REQ-016 SHALL use FSM with states IDLE and SHIFT, plus bit counter cnt of width clog2(DATA_W), range 0..DATA_W-1.
REQ-017 IDLE -> SHIFT at an edge where all pending bits are 1: all holdings copied to shift registers, all pending cleared, cnt = 0.
REQ-018 In SHIFT, cnt SHALL increment each edge; the shift register SHALL shift toward the output end, zero-filled.
REQ-019 At an edge with cnt = DATA_W-1: if all pending = 1, reload per REQ-017 and stay in SHIFT (no gap cycle); otherwise go to IDLE.
REQ-020 serial_out[c] SHALL be shift[c] bit 0 (MSB_FIRST=0) or bit DATA_W-1 (MSB_FIRST=1) in SHIFT, and 0 in IDLE.
REQ-021 OutReady SHALL be 1 exactly while in SHIFT; frame_start SHALL be 1 while in SHIFT with cnt = 0.
REQ-022 Latency: last channel finish at edge k -> bit 0 presented after edge k+1; bit i after edge k+1+i.
REQ-023 ch_finish[c] on the same edge as a transfer SHALL load holding[c] with the new word and leave pending[c] = 1; no overrun.
REQ-024 ch_finish[c] while pending[c] = 1 and no transfer on that edge SHALL discard the new word, keep the old one, and set overrun[c].
REQ-025 flush SHALL take priority over ch_finish and transfer: state IDLE, cnt 0, pending and overrun cleared, shift registers zeroed.
REQ-026 Channels SHALL be independent except for the all-pending transfer condition; N_CH = 1 SHALL work without special-casing.

Reset
REQ-027 uni_reset_n low SHALL immediately force IDLE, cnt 0, all holdings/shift registers 0, pending 0, overrun 0.
REQ-028 During reset, OutReady, serial_out, and frame_start SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; after release, no bits SHALL be emitted until new words arrive on all channels.

Verification
REQ-030 Defaults: finish both at edge 0, L=40'h00_0000_0005, R=40'h80_0000_0001 -> after edge 1 OutReady=1, frame_start=1, serial_out=2'b11; after edge 2, serial_out=2'b00; after edge 3, L=1, R=0; after edge 41, OutReady=0.
REQ-031 Back-to-back: second word pair loaded during frame -> OutReady stays high across 80 cycles; frame_start pulses exactly twice, 40 cycles apart.
REQ-032 Skew: finish L at edge 0, finish R at edge 10 -> no output until after edge 11; pending=2'b01 during edges 1..10.
REQ-033 Overrun: two finish L pulses with R idle -> overrun=2'b01, first L word is emitted, flush clears overrun.
REQ-034 MSB_FIRST=1, DATA_W=8, word 8'hA5 -> serial bits 1,0,1,0,0,1,0,1.
REQ-035 Reset asserted at bit 20 -> all outputs 0 immediately; after release, the line stays idle until a new full word set arrives.
